// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC, reads operands
// with write-back bypass and holds one issued entry behind a valid/ready handshake.
module alu_issue_stage #(
  parameter bit BYPASS_EN      = 1'b1,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  alu_op_o,
  output logic [4:0]  rd_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic        r_ill;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_f7b5;
  logic        w_is_op;
  logic        w_f7_zero;
  logic        w_f7_alt_ok;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_shamt;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [2:0]  w_op;
  logic [4:0]  w_rd;
  logic        w_ill;
  logic        w_accept;

  function automatic logic [31:0] read_operand(input logic [4:0] addr, input logic [31:0] rf_data,
                                               input logic we, input logic [4:0] wb_rd,
                                               input logic [31:0] wb_data);
    if (addr == 5'd0)
      return 32'd0;
    else if (BYPASS_EN && we && (wb_rd == addr))
      return wb_data;
    else
      return rf_data;
  endfunction

  assign rs1_addr_o  = instr_i[19:15];
  assign rs2_addr_o  = instr_i[24:20];
  assign w_opcode    = instr_i[6:0];
  assign w_f3        = instr_i[14:12];
  assign w_f7        = instr_i[31:25];
  assign w_f7b5      = instr_i[30];
  assign w_is_op     = (w_opcode == OPC_OP);
  assign w_f7_zero   = (w_f7 == 7'b0000000);
  assign w_f7_alt_ok = w_f7_zero || (w_f7 == 7'b0100000);
  assign w_imm_i     = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_u     = {instr_i[31:12], 12'b0};
  assign w_shamt     = {27'd0, instr_i[24:20]};
  assign w_rs1_val   = read_operand(rs1_addr_o, rs1_data_i, wb_we_i, wb_rd_i, wb_data_i);
  assign w_rs2_val   = read_operand(rs2_addr_o, rs2_data_i, wb_we_i, wb_rd_i, wb_data_i);

  // Shift immediates carry only the shift amount in operand b.
  always_comb begin
    w_a   = w_rs1_val;
    w_b   = w_rs2_val;
    w_op  = 3'b000;
    w_rd  = instr_i[11:7];
    w_ill = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_IMM: begin
        if (!w_is_op)
          w_b = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) ? w_shamt : w_imm_i;
        case (w_f3)
          3'b000: begin
            w_op  = (w_is_op && w_f7b5) ? 3'b001 : 3'b000;
            w_ill = w_is_op && !w_f7_alt_ok;
          end
          3'b001: begin
            w_op  = 3'b101;
            w_ill = !w_f7_zero;
          end
          3'b100: begin
            w_op  = 3'b100;
            w_ill = w_is_op && !w_f7_zero;
          end
          3'b101: begin
            w_op  = w_f7b5 ? 3'b111 : 3'b110;
            w_ill = !w_f7_alt_ok;
          end
          3'b110: begin
            w_op  = 3'b011;
            w_ill = w_is_op && !w_f7_zero;
          end
          3'b111: begin
            w_op  = 3'b010;
            w_ill = w_is_op && !w_f7_zero;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_a = 32'd0;
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = pc_i;
        w_b = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill && NOP_ON_ILLEGAL) begin
      w_a  = 32'd0;
      w_b  = 32'd0;
      w_op = 3'b000;
      w_rd = 5'd0;
    end
  end

  assign in_ready_o = !r_valid || out_ready_i;
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 3'b000;
      r_rd    <= 5'd0;
      r_ill   <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_op    <= w_op;
      r_rd    <= w_rd;
      r_ill   <= w_ill;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign a_o         = r_a;
  assign b_o         = r_b;
  assign alu_op_o    = r_op;
  assign rd_o        = r_rd;
  assign illegal_o   = r_ill;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the ALU in the nano_rv32i core.
- Accepts a fetched instruction and PC, decodes RV32I OP, OP-IMM, LUI and AUIPC, and reads register operands with write-back bypass.
- Registers the ALU operands, the 3-bit ALU opcode and the destination register, then hands them downstream over a valid/ready handshake.
- Instructions the ALU cannot execute are flagged as illegal.

Parameters:
- BYPASS_EN, 1, when 1 the write-back port forwards into the operand read; when 0 the register file data is used as-is.
- NOP_ON_ILLEGAL, 1, when 1 an illegal instruction is issued with a=b=0, alu_op=000 and rd=0; when 0 the raw decode fields are passed through.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- in_valid_i  input  1  instruction and PC are valid.
- in_ready_o  output  1  stage can accept the instruction this cycle.
- instr_i  input  32  instruction word.
- pc_i  input  32  instruction address.
- flush_i  input  1  kill the held entry and any accept this cycle.
- rs1_addr_o  output  5  register file read address 1 = instr_i[19:15] (combinational).
- rs2_addr_o  output  5  register file read address 2 = instr_i[24:20] (combinational).
- rs1_data_i  input  32  register file read data 1 (same cycle).
- rs2_data_i  input  32  register file read data 2 (same cycle).
- wb_we_i  input  1  write-back write enable.
- wb_rd_i  input  5  write-back destination.
- wb_data_i  input  32  write-back data.
- out_valid_o  output  1  issued entry valid.
- out_ready_i  input  1  downstream (ALU/EX) accepts the entry.
- a_o  output  32  ALU operand a (registered).
- b_o  output  32  ALU operand b (registered).
- alu_op_o  output  3  ALU opcode (registered).
- rd_o  output  5  destination register (registered).
- illegal_o  output  1  issued instruction unsupported (registered).

Behaviour:
- Reset (asynchronous, rst_i=1): out_valid_o=0, a_o=0, b_o=0, alu_op_o=000, rd_o=0, illegal_o=0.
- Single-entry pipeline register; latency 1 cycle from accept to out_valid_o.
- in_ready_o = !out_valid_o | out_ready_i. It is combinational and does not depend on in_valid_i.
- Accept occurs when in_valid_i & in_ready_o & !flush_i; the entry is loaded and out_valid_o=1 next cycle.
- Drain without accept (out_ready_i=1, no accept): out_valid_o=0 next cycle; data outputs hold their last values.
- Backpressure (out_valid_o=1, out_ready_i=0): all outputs hold stable; in_ready_o=0.
- flush_i=1: out_valid_o=0 next cycle and the input is not accepted, whatever the other signals. Flush has priority over accept.
- Operand read: value = 0 if the address is 0. Otherwise it is wb_data_i if BYPASS_EN & wb_we_i & wb_rd_i==address. Otherwise it is rs*_data_i.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7b5 = instr[30]):
  - OP (0110011): a=rs1, b=rs2. f3 000 gives 000 if f7b5=0, else 001. f3 111→010, 110→011, 100→100, 001→101. f3 101 gives 110 if f7b5=0, else 111. f3 010/011 (SLT/SLTU) → illegal. Other instr[31:25] bits not 0 (or 0100000 where f7b5 applies) → illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20]. f3 000→000, 111→010, 110→011, 100→100. SLLI→101 and requires instr[31:25]=0. SRLI/SRAI→110/111 by f7b5, and require the other funct7 bits to be 0. f3 010/011 → illegal.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, op 000.
  - AUIPC (0010111): a=pc_i, b={instr[31:12],12'b0}, op 000.
  - Any other opcode → illegal.
- rd_o = instr[11:7] for legal instructions.
- Illegal entry: illegal_o=1 and the entry is still issued with out_valid_o=1. When NOP_ON_ILLEGAL=1, a=b=0, op=000, rd=0.
- Arithmetic: all operand values are 32-bit; immediates are sign-extended from bit 31.
- Reset mid-handshake: the entry is discarded immediately; in_ready_o=1 while rst_i is asserted.

Test Plan:
- ADDI x5,x1,-1 with rs1_data=7 -> next cycle out_valid=1, a=7, b=0xFFFFFFFF, alu_op=000, rd=5, illegal=0.
- SUB x3,x1,x2 with wb_we=1, wb_rd=2, wb_data=9, rs2_data=4 (BYPASS_EN=1) -> b=9, alu_op=001; a read of x0 returns 0 even with wb_rd=0, wb_we=1.
- AUIPC x1,0x12345 at pc=0x100 -> a=0x100, b=0x12345000, op=000. SRAI x4,x4,3 -> b=3, op=111.
- Backpressure: hold out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs stable; release -> next instruction issued the following cycle with no loss or duplication.
- SLT x1,x2,x3 and opcode 1100011 -> illegal=1, a=b=0, rd=0. Flush asserted with out_valid=1 -> out_valid=0 next cycle and no accept.
- Assert rst_i asynchronously mid-stall -> all outputs zero before the next clock edge; first instruction after release issues normally.
